uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
// Consumes the core's 9-bit UART store port ([8]=strobe, [7:0]=byte) and turns it into a
// real 8N1 serial line. Sits directly downstream of RV32IM's uart_out and replaces the
// $write sim model on FPGA builds. Buffers bytes in a FIFO so the core never stalls.
// Overflow drops the byte and is flagged sticky.
// PARAMETERS
// CLKS_PER_BIT  16  clock cycles per serial bit; legal range >=2
// FIFO_DEPTH    16  byte FIFO entries; must be a power of 2, >=2
// FIFO_AW        4  log2(FIFO_DEPTH)
// PORTS
// clock       in   1          single clock, rising edge
// reset       in   1          synchronous, active-high
// uart_in     in   9          [8]=push strobe, [7:0]=byte; RV32IM uart_out format
// tx          out  1          serial line, idle high, registered
// busy        out  1          state!=IDLE || fifo_count!=0
// fifo_count  out  FIFO_AW+1  bytes currently buffered
// overflow    out  1          sticky; set when a push hits a full FIFO
// BEHAVIOUR
// - Reset: tx=1, busy=0, fifo_count=0, overflow=0, state=IDLE, baud counter=0.
// - Reset mid-frame aborts the frame. tx returns high the cycle after reset is sampled.
//   FIFO is flushed.
// - Push: every cycle with uart_in[8]=1 writes one byte. There is no edge detection;
//   the core holds the strobe for exactly one cycle per store.
// - FIFO full and a push with no pop in the same cycle: the byte is dropped and
//   overflow<=1.
// - Full, push and pop in the same cycle: the pop frees a slot, the push is accepted,
//   count is unchanged, and no overflow is raised.
// - Pointers wrap modulo FIFO_DEPTH. There is no fall-through: the pop decision uses
//   the registered count.
// - FSM states IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1.
//   Each state or bit holds for exactly CLKS_PER_BIT cycles.
// - IDLE: if count!=0, pop into shift_reg, go to START, clear the baud counter.
// - START: tx=0. DATA: 8 bits, LSB first, with a bit index 0..7. STOP: tx=1.
// - Last cycle of STOP: if count!=0, pop and go to START directly (no gap). Otherwise
//   go to IDLE.
// - Latency: byte pushed at edge N lands in the FIFO. IDLE pops at edge N+1. tx is low
//   from edge N+2.
// - Back-to-back frame period is exactly 10*CLKS_PER_BIT cycles.
// - tx is driven from a register (no combinational glitches). fifo_count is registered.
// STRUCTURE
// - Shared header uart_defs.vh holds the FSM state localparams (2-bit) and
//   UART_FRAME_BITS=10.
// - Sub-module uart_tx_fifo: synchronous FIFO, params DEPTH/AW.
//   Ports: push, din, pop, dout, count, full, empty.
// - dout is valid combinationally for the head entry.
// - Top level: FIFO, FSM, baud counter, bit index, shift register, sticky overflow.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=16)
// 1. Reset held for 3 cycles, then idle for 100 cycles
//    -> tx=1, busy=0, fifo_count=0, overflow=0 throughout.
// 2. Push 0x41 at edge N -> tx low for cycles N+2..N+5, then data bits 1,0,0,0,0,0,1,0
//    (4 cycles each), then stop high for 4 cycles. busy=0 after.
// 3. Push 0x48,0x69,0x0A on consecutive cycles -> three contiguous frames of 40 cycles
//    each. The bench decoder reads "Hi\n". overflow=0.
// 4. Push 18 bytes 0x00..0x11 on consecutive cycles -> 0x00 is sent. fifo_count peaks
//    at 16, 0x11 is dropped, and overflow=1 until reset.
// 5. With the FIFO full (16), push and pop in the same cycle at the end of STOP
//    -> fifo_count stays 16, overflow stays 0.
// 6. Assert reset during DATA bit 3 -> tx=1 next cycle, fifo_count=0, overflow=0.
//    Push 0x55 after release -> clean frame 0,1,0,1,0,1,0,1,0,1.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the 8N1 UART transmit serializer.
package uart_tx_serializer_pkg;

    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned DATA_BITS       = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; head entry is readable combinationally on dout.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffers bytes from the core's 9-bit UART store port and shifts them out as 8N1 frames.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [8:0]         uart_in,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int unsigned BaudW    = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LastBit  = 3'(DATA_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;

    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (uart_in[8]),
        .din   (uart_in[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_end = (baud_q == BaudLast);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d    = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LastBit) state_d = StStop;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so frames stay gapless.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign ovf_d = ovf_q | (uart_in[8] & fifo_full & ~fifo_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != StIdle) || (fifo_count != '0);

endmodule
